// File: rtl/stack_cpu_mc_ctrl_pkg.sv
// Shared codes for the stack CPU multi-cycle controller: opcodes, select/function/fault codes, FSM states.
// Replaces the old stack_cpu_defs.vh header; importers use stack_cpu_mc_ctrl_pkg::*.
package stack_cpu_mc_ctrl_pkg;

    localparam logic [4:0] OPC_PUSH = 5'b00000;
    localparam logic [4:0] OPC_POP  = 5'b00001;
    localparam logic [4:0] OPC_ADD  = 5'b00010;
    localparam logic [4:0] OPC_NEG  = 5'b00011;
    localparam logic [4:0] OPC_OR   = 5'b00100;
    localparam logic [4:0] OPC_NOT  = 5'b00101;
    localparam logic [4:0] OPC_CALL = 5'b00110;
    localparam logic [4:0] OPC_RET  = 5'b00111;

    localparam logic [2:0] FN_PASS = 3'b000;
    localparam logic [2:0] FN_ADD  = 3'b010;
    localparam logic [2:0] FN_NEG  = 3'b011;
    localparam logic [2:0] FN_OR   = 3'b100;
    localparam logic [2:0] FN_NOT  = 3'b101;

    localparam logic [1:0] ADDR_PC  = 2'd0;
    localparam logic [1:0] ADDR_SP  = 2'd1;
    localparam logic [1:0] ADDR_SP1 = 2'd2;

    localparam logic [1:0] PCS_INC = 2'd0;
    localparam logic [1:0] PCS_REL = 2'd1;
    localparam logic [1:0] PCS_MEM = 2'd2;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_BUS     = 2'b10;
    localparam logic [1:0] FLT_STACK   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_PUSH, OP_POP, OP_ADD, OP_NEG, OP_OR, OP_NOT, OP_CALL, OP_RET
    } op_t;

    // Datapath strobes issued together in the single EXEC cycle.
    typedef struct packed {
        logic       ld_pc;
        logic       ld_sp;
        logic       ld_reg;
        logic       ld_flg;
        logic       sp_dec;
        logic [1:0] pc_sel;
        logic [2:0] func_sel;
    } exec_t;

    function automatic exec_t mk_exec(input logic pc, input logic sp, input logic rg,
                                      input logic flg, input logic dec,
                                      input logic [1:0] psel, input logic [2:0] fn);
        exec_t e;
        e.ld_pc    = pc;
        e.ld_sp    = sp;
        e.ld_reg   = rg;
        e.ld_flg   = flg;
        e.sp_dec   = dec;
        e.pc_sel   = psel;
        e.func_sel = fn;
        return e;
    endfunction

endpackage

// File: rtl/stack_cpu_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle: memory handshake, instruction data, load strobes and selects.
interface stack_cpu_mc_ctrl_if;
    logic [15:0] ir_in;
    logic        mem_ack;
    logic [15:0] sp_value;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  addr_sel;
    logic        din_sel;
    logic        ld_ir;
    logic        ld_pc;
    logic        ld_sp;
    logic        ld_reg;
    logic        ld_flg;
    logic        sp_dec;
    logic [1:0]  pc_sel;
    logic [2:0]  func_sel;
    logic [15:0] ir;
    logic        halted;
    logic [1:0]  fault;

    modport master (
        input  ir_in, mem_ack, sp_value,
        output mem_req, mem_we, addr_sel, din_sel, ld_ir, ld_pc, ld_sp, ld_reg, ld_flg,
               sp_dec, pc_sel, func_sel, ir, halted, fault
    );

    modport slave (
        output ir_in, mem_ack, sp_value,
        input  mem_req, mem_we, addr_sel, din_sel, ld_ir, ld_pc, ld_sp, ld_reg, ld_flg,
               sp_dec, pc_sel, func_sel, ir, halted, fault
    );
endinterface

// File: rtl/stack_cpu_mc_ctrl_decode.sv
// Combinational opcode decode: op class, memory direction, EXEC strobe set and legality.
module stack_op_decode
    import stack_cpu_mc_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_t        op,
    output logic       legal,
    output logic       is_read,
    output logic       is_write,
    output exec_t      exec
);
    always_comb begin
        op       = OP_PUSH;
        legal    = 1'b1;
        is_read  = 1'b0;
        is_write = 1'b0;
        exec     = '0;
        case (opcode)
            OPC_PUSH: begin op = OP_PUSH; is_write = 1'b1; exec = mk_exec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PCS_INC, FN_PASS); end
            OPC_CALL: begin op = OP_CALL; is_write = 1'b1; exec = mk_exec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PCS_REL, FN_PASS); end
            OPC_POP:  begin op = OP_POP;  is_read  = 1'b1; exec = mk_exec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, PCS_INC, FN_PASS); end
            OPC_ADD:  begin op = OP_ADD;  is_read  = 1'b1; exec = mk_exec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, PCS_INC, FN_ADD);  end
            OPC_OR:   begin op = OP_OR;   is_read  = 1'b1; exec = mk_exec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, PCS_INC, FN_OR);   end
            OPC_RET:  begin op = OP_RET;  is_read  = 1'b1; exec = mk_exec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PCS_MEM, FN_PASS); end
            OPC_NEG:  begin op = OP_NEG;  exec = mk_exec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, PCS_INC, FN_NEG); end
            OPC_NOT:  begin op = OP_NOT;  exec = mk_exec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, PCS_INC, FN_NOT); end
            default:  legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/stack_cpu_mc_ctrl.sv
// Multi-cycle sequencer for the 16-bit stack CPU: fetch/decode/memory/exec over a req/ack memory port.
// Optional stack bounds checking is compiled in with `define STACK_GUARD_EN.
module stack_cpu_mc_ctrl
    import stack_cpu_mc_ctrl_pkg::*;
#(
    parameter logic [3:0]  WAIT_LIMIT = 4'd15,
    parameter logic [15:0] SP_MIN     = 16'h0000,
    parameter logic [15:0] SP_MAX     = 16'h0013
) (
    input  logic                  clock,
    input  logic                  reset,
    stack_cpu_mc_ctrl_if.master   bus
);
    state_t      state;
    logic [15:0] ir;
    logic [1:0]  fault;
    logic [3:0]  wait_cnt;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  addr_sel;
    logic        din_sel;
    logic        halted;
    exec_t       strobe;

    op_t   dec_op;
    logic  dec_legal;
    logic  dec_read;
    logic  dec_write;
    exec_t dec_exec;

    stack_op_decode u_decode (
        .opcode   (ir[15:11]),
        .op       (dec_op),
        .legal    (dec_legal),
        .is_read  (dec_read),
        .is_write (dec_write),
        .exec     (dec_exec)
    );

    logic wait_expired;
    logic stack_bad;
    assign wait_expired = (wait_cnt == WAIT_LIMIT - 4'd1);

`ifdef STACK_GUARD_EN
    assign stack_bad = (dec_write && bus.sp_value == SP_MIN) ||
                       (dec_read  && bus.sp_value == SP_MAX);
`else
    logic unused_guard;
    assign unused_guard = ^{bus.sp_value, SP_MIN, SP_MAX};
    assign stack_bad    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            ir       <= '0;
            fault    <= FLT_NONE;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            addr_sel <= ADDR_PC;
            din_sel  <= 1'b0;
            halted   <= 1'b0;
            strobe   <= '0;
        end else begin
            strobe <= '0;
            case (state)
                S_FETCH: begin
                    // First cycle after reset has no request yet; raise it here.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        addr_sel <= ADDR_PC;
                        din_sel  <= 1'b0;
                        wait_cnt <= '0;
                    end else if (bus.mem_ack) begin
                        ir      <= bus.ir_in;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end else if (wait_expired) begin
                        fault   <= FLT_BUS;
                        halted  <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        fault  <= FLT_ILLEGAL;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (stack_bad) begin
                        fault  <= FLT_STACK;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (dec_write) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        addr_sel <= ADDR_SP;
                        din_sel  <= (dec_op == OP_CALL);
                        wait_cnt <= '0;
                        state    <= S_MEM_WR;
                    end else if (dec_read) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        addr_sel <= ADDR_SP1;
                        din_sel  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_MEM_RD;
                    end else begin
                        strobe <= dec_exec;
                        state  <= S_EXEC;
                    end
                end
                S_MEM_RD, S_MEM_WR: begin
                    if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        strobe  <= dec_exec;
                        state   <= S_EXEC;
                    end else if (wait_expired) begin
                        fault   <= FLT_BUS;
                        halted  <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_EXEC: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    addr_sel <= ADDR_PC;
                    din_sel  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                end
            endcase
        end
    end

    // IR load must coincide with the ack cycle, so it is the one combinational strobe.
    assign bus.ld_ir    = (state == S_FETCH) && mem_req && bus.mem_ack;
    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.addr_sel = addr_sel;
    assign bus.din_sel  = din_sel;
    assign bus.ld_pc    = strobe.ld_pc;
    assign bus.ld_sp    = strobe.ld_sp;
    assign bus.ld_reg   = strobe.ld_reg;
    assign bus.ld_flg   = strobe.ld_flg;
    assign bus.sp_dec   = strobe.sp_dec;
    assign bus.pc_sel   = strobe.pc_sel;
    assign bus.func_sel = strobe.func_sel;
    assign bus.ir       = ir;
    assign bus.halted   = halted;
    assign bus.fault    = fault;

endmodule
